cmod_uart_rx: RTL and testbench

//   UART receiver for the CMOD-A7 board top. Sits between pad uart_txd_in and the

---
 rtl/cmod_uart_rx.sv | 199 +++++++++++++++++++
 tb/tb_cmod_uart_rx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmod_uart_rx.sv
// cmod_uart_rx: 8N1 UART receiver with an 8-entry receive FIFO.
// A 2-flop synchroniser feeds a mid-bit sampling FSM. Completed bytes are
// pushed into a circular buffer, and the core pops them through a valid/ready port.
// Build option: define CMOD_UART_RX_PARITY_EN to receive 8E1 frames instead,
// with a parity check.
//
// Handshake: the FIFO pops on every sysclk edge where rx_valid && rx_ready.
// rx_data is the head entry and stays stable while rx_valid=1 and rx_ready=0.
//
// dbg_state encoding: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 BREAK.
module cmod_uart_rx #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             sysclk,
    input  logic                             rst_n,
    input  logic                             uart_txd_in,
    output logic [7:0]                       rx_data,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             frame_err,
    output logic                             parity_err,
    output logic                             overrun,
    input  logic                             overrun_clr,
    output logic [2:0]                       dbg_state
);
    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t          state;
    logic            sync1;
    logic            rxs;
    logic [TW-1:0]   tmr;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            stop_sample;
    logic            par_ok;
    logic            push;
`ifdef CMOD_UART_RX_PARITY_EN
    logic            par_bit;
`endif

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            full;
    logic            pop;
    logic            accept;

    // Two-flop synchroniser. It resets to idle-high, so reset release cannot look like a start bit.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_txd_in;
            rxs   <= sync1;
        end
    end

    assign stop_sample = (state == S_STOP) && (tmr == '0);
`ifdef CMOD_UART_RX_PARITY_EN
    assign par_ok = ~(^{par_bit, shreg});
`else
    assign par_ok = 1'b1;
`endif
    // The byte is written on the same edge as the stop-bit sample.
    assign push = stop_sample && rxs && par_ok;

    // Frame FSM: half-bit delay to the middle of the start bit, then whole-bit steps.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tmr        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
`ifdef CMOD_UART_RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        tmr   <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (tmr != '0) begin
                        tmr <= tmr - TW'(1);
                    end else if (rxs) begin
                        state <= S_IDLE;
                    end else begin
                        state   <= S_DATA;
                        tmr     <= FULL_LOAD;
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (tmr != '0) begin
                        tmr <= tmr - TW'(1);
                    end else begin
                        shreg   <= {rxs, shreg[7:1]};
                        tmr     <= FULL_LOAD;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef CMOD_UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef CMOD_UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tmr != '0) begin
                        tmr <= tmr - TW'(1);
                    end else begin
                        par_bit <= rxs;
                        tmr     <= FULL_LOAD;
                        state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tmr != '0) begin
                        tmr <= tmr - TW'(1);
                    end else begin
                        parity_err <= ~par_ok;
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

    assign rx_valid = (fifo_count != '0);
    assign full     = (fifo_count == CW'(FIFO_DEPTH));
    assign pop      = rx_valid & rx_ready;
    // When the FIFO is full, a pop in the same cycle frees the head slot for the incoming byte.
    assign accept   = push & (~full | pop);
    assign rx_data  = mem[rd_ptr];

    // Receive FIFO storage, pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push && !accept) overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmod_uart_rx.sv
// Bench for cmod_uart_rx at default parameters (104 clocks per bit, 8-entry FIFO).
// Define CMOD_UART_RX_PARITY_EN for both bench and design to cover the 8E1 build.
module tb_cmod_uart_rx;
    localparam int CPB   = 104;
    localparam int DEPTH = 8;
`ifdef CMOD_UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Start edge: 2 synchroniser clocks plus 1 detect clock. The start-bit sample
    // then comes CPB/2 clocks later, and each further bit is one CPB later. The stop
    // sample is therefore at clock 55 + CPB*(NB-1) after the start-bit edge.
    localparam int LAT_EDGE = 3 + CPB / 2 + CPB * (NB - 1);

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_txd_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [3:0] fifo_count;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       overrun_clr = 1'b0;
    logic [2:0] dbg_state;

    int total = 0;
    int bad = 0;
    int fe_pulses = 0;
    int pe_pulses = 0;

    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0;

    cmod_uart_rx dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .uart_txd_in (uart_txd_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .fifo_count  (fifo_count),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .dbg_state   (dbg_state)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (frame_err === 1'b1) fe_pulses++;
        if (parity_err === 1'b1) pe_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr = 1'b1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
        chk({tag, "_valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
        chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
        if (exp_q.size() != 0) chk({tag, "_head"}, 32'(rx_data), 32'(exp_q[0]));
    endtask

    task automatic pop_one(input string tag);
        chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
        chk({tag, "_data"}, 32'(rx_data), 32'(exp_q[0]));
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        void'(exp_q.pop_front());
    endtask

    // mode 0: plain frame; 1: check rx_valid rises exactly one clock after the
    // stop sample (FIFO must be empty); 2: pop on the push edge (FIFO must be full)
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic par_flip, input int mode);
        logic [10:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
        if (NB == 11) begin
            bits[9]  = (^b) ^ par_flip;
            bits[10] = stop_bit;
        end else begin
            bits[9] = stop_bit;
        end
        n = 0;
        for (int i = 0; i < NB; i++) begin
            uart_txd_in = bits[i];
            for (int c = 0; c < CPB; c++) begin
                if (mode == 2 && n == LAT_EDGE - 1) begin
                    rx_ready = 1'b1;
                    chk("pushpop_head", 32'(rx_data), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                tick(1);
                n++;
                if (mode == 2 && n == LAT_EDGE) rx_ready = 1'b0;
                if (mode == 1 && n == LAT_EDGE - 1) chk("lat_before", 32'(rx_valid), 32'd0);
                if (mode == 1 && n == LAT_EDGE) chk("lat_after", 32'(rx_valid), 32'd1);
            end
        end
    endtask

    initial begin
        int fe0;
        int pe0;
        logic [7:0] b;

        // reset values
        tick(4);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick(10);

        // back-to-back 0x55, 0xA3 without popping
        send_frame(8'h55, 1'b1, 1'b0, 1);
        model_push(8'h55);
        send_frame(8'hA3, 1'b1, 1'b0, 0);
        model_push(8'hA3);
        tick(2);
        chk("b2b_count", 32'(fifo_count), 32'd2);
        chk("b2b_head", 32'(rx_data), 32'h55);
        tick(5);
        chk("b2b_hold", 32'(rx_data), 32'h55);
        pop_one("b2b_pop1");
        chk("b2b_second", 32'(rx_data), 32'hA3);
        pop_one("b2b_pop2");
        chk("b2b_empty", 32'(rx_valid), 32'd0);
        rx_ready = 1'b1;
        tick(2);
        rx_ready = 1'b0;
        chk("empty_pop_count", 32'(fifo_count), 32'd0);

        // 40-clock low glitch on an idle line
        fe0 = fe_pulses;
        tick(50);
        uart_txd_in = 1'b0;
        tick(20);
        chk("glitch_busy", 32'(dbg_state != 3'd0), 32'd1);
        tick(20);
        uart_txd_in = 1'b1;
        tick(15);
        chk("glitch_idle", 32'(dbg_state), 32'd0);
        chk("glitch_count", 32'(fifo_count), 32'd0);
        chk("glitch_ferr", 32'(fe_pulses - fe0), 32'd0);

        // framing error then break; the next good frame still arrives
        fe0 = fe_pulses;
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        tick(3 * CPB);
        chk("break_held", 32'(dbg_state != 3'd0), 32'd1);
        uart_txd_in = 1'b1;
        tick(20);
        chk("ferr_pulses", 32'(fe_pulses - fe0), 32'd1);
        chk("ferr_count", 32'(fifo_count), 32'd0);
        chk("ferr_idle", 32'(dbg_state), 32'd0);
        send_frame(8'h7E, 1'b1, 1'b0, 0);
        model_push(8'h7E);
        tick(2);
        check_state("after_ferr");
        pop_one("after_ferr_pop");

        // nine frames into an 8-deep FIFO
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 0);
            model_push(8'(i));
        end
        tick(2);
        chk("ovr_count", 32'(fifo_count), 32'd8);
        chk("ovr_flag", 32'(overrun), 32'd1);
        for (int i = 1; i <= 8; i++) pop_one("ovr_pop");
        chk("ovr_sticky", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        exp_ovr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);

        // full FIFO, pop on the push edge of 0xF0
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, 1'b0, 0);
            model_push(b);
        end
        send_frame(8'hF0, 1'b1, 1'b0, 2);
        model_push(8'hF0);
        tick(2);
        chk("fullpop_count", 32'(fifo_count), 32'd8);
        chk("fullpop_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 7; i++) pop_one("fullpop_pop");
        chk("fullpop_last", 32'(rx_data), 32'hF0);
        pop_one("fullpop_pop_last");

        // randomized traffic against the queue model
        for (int k = 0; k < 12; k++) begin
            tick($urandom_range(0, 200));
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, 1'b0, 0);
            model_push(b);
            tick(2);
            check_state("rand");
            for (int p = $urandom_range(0, 1); p > 0; p--) begin
                if (exp_q.size() != 0) pop_one("rand_pop");
            end
            if ($urandom_range(0, 3) == 0) begin
                overrun_clr = 1'b1;
                tick(1);
                overrun_clr = 1'b0;
                exp_ovr = 1'b0;
                chk("rand_clr", 32'(overrun), 32'd0);
            end
        end

        // reset in the middle of the data bits of 0xC5
        send_frame(8'h11, 1'b1, 1'b0, 0);
        model_push(8'h11);
        fe0 = fe_pulses;
        uart_txd_in = 1'b0;
        tick(CPB);
        uart_txd_in = 1'b1;
        tick(CPB);
        uart_txd_in = 1'b0;
        tick(CPB);
        uart_txd_in = 1'b1;
        tick(CPB);
        uart_txd_in = 1'b0;
        tick(CPB / 2);
        rst_n = 1'b0;
        tick(5);
        chk("midrst_valid", 32'(rx_valid), 32'd0);
        chk("midrst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        exp_ovr = 1'b0;
        tick(10);
        uart_txd_in = 1'b1;
        tick(2 * CPB);
        chk("postrst_count", 32'(fifo_count), 32'd0);
        chk("postrst_valid", 32'(rx_valid), 32'd0);
        chk("postrst_data", 32'(rx_data), 32'd0);
        chk("postrst_ovr", 32'(overrun), 32'd0);
        chk("postrst_ferr", 32'(fe_pulses - fe0), 32'd0);
        chk("postrst_state", 32'(dbg_state), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        model_push(8'h5A);
        tick(2);
        check_state("postrst_rx");
        pop_one("postrst_pop");

`ifdef CMOD_UART_RX_PARITY_EN
        // even parity: a good 0x81 is kept, a flipped parity bit is discarded
        pe0 = pe_pulses;
        send_frame(8'h81, 1'b1, 1'b0, 0);
        model_push(8'h81);
        tick(2);
        check_state("par_good");
        chk("par_good_perr", 32'(pe_pulses - pe0), 32'd0);
        send_frame(8'h81, 1'b1, 1'b1, 0);
        tick(2);
        check_state("par_bad");
        chk("par_bad_perr", 32'(pe_pulses - pe0), 32'd1);
        pop_one("par_pop");
`else
        pe0 = 0;
        chk("no_parity_err", 32'(pe_pulses - pe0), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
